ama_riscv_dmem_arbiter: RTL and testbench
=========================================

# ama_riscv_dmem_arbiter

Two-requester arbiter for the single-port, synchronous-read data memory (14-bit word address, 4-bit byte write enable, 32-bit data, 1-cycle read latency). It sits between the core's DMEM port and the DMEM macro. It shares the DMEM with a secondary debug/loader requester used for memory preload, inspection and MMIO-side access. The core has priority, but starvation of the debug port is bounded and a lock mode supports bursts; the core is held off through a stall output.

## Interface
Parameters:
- MAX_WAIT, 4: cycles a pending debug request may lose to the core before it is forced through. Legal range is 1..255.
- CNT_W, $clog2(MAX_WAIT+1): width of the wait counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- core_en  in  1  core access request for this cycle.
- core_we  in  4  core byte write enables; 0 means read.
- core_addr  in  14  core word address.
- core_wdata  in  32  core write data.
- core_stall  out  1  core access not performed this cycle; the core holds its request.
- core_rdata  out  32  read data for the core's granted read of the previous cycle.
- dbg_req  in  1  debug access request; held until dbg_gnt.
- dbg_lock  in  1  debug requests exclusive ownership (burst).
- dbg_we  in  4  debug byte write enables; 0 means read.
- dbg_addr  in  14  debug word address.
- dbg_wdata  in  32  debug write data.
- dbg_gnt  out  1  debug access performed this cycle.
- dbg_rvalid  out  1  dbg_rdata valid (granted debug read of the previous cycle).
- dbg_rdata  out  32  debug read data.
- dmem_en  out  1  DMEM enable.
- dmem_we  out  4  DMEM byte write enables.
- dmem_addr  out  14  DMEM address.
- dmem_din  out  32  DMEM write data.
- dmem_dout  in  32  DMEM read data, 1 cycle after the access.

## Operation
- **FSM states:** S_CORE (reset state) and S_LOCK.
- **Owner selection is combinational each cycle:**
  - In S_LOCK, debug owns the port.
  - In S_CORE, debug owns the port if dbg_req && (!core_en || wait_cnt == MAX_WAIT). Otherwise the core owns it.
- **Outputs:**
  - dbg_gnt = dbg_req && debug owns.
  - core_stall = core_en && !(core owns).
- **DMEM mux:**
  - Routes the owner's we/addr/wdata.
  - dmem_en = granted core_en or dbg_gnt.
  - The non-owner's inputs never reach the DMEM.
  - When there is no access: dmem_en=0, dmem_we=0.
- **wait_cnt:**
  - Clears when dbg_req=0 or dbg_gnt=1.
  - Otherwise increments and saturates at MAX_WAIT.
- **Transitions:**
  - S_CORE -> S_LOCK when dbg_gnt && dbg_lock.
  - S_LOCK -> S_CORE when dbg_lock=0 (sampled at the clock edge). dbg_gnt in that cycle still follows lock ownership.
  - While in S_LOCK, the core is stalled whenever core_en=1, even if dbg_req=0.
- **Read return:**
  - A registered rd_owner tag records which requester performed a read (we==0) access.
  - dbg_rvalid is registered: it is 1 in the cycle after a granted debug read, 0 after a debug write.
  - dbg_rdata and core_rdata both pass dmem_dout through. The core must only consume core_rdata after a non-stalled read.
- **Writes:** complete at the granting edge. No write response is returned.

## Timing
- **Grant latency:**
  - Debug read with the core idle: 0 cycles to dbg_gnt, with dbg_rvalid on the next cycle.
  - Worst case under continuous core traffic: dbg_gnt in the (MAX_WAIT+1)th cycle of the request.
- **Stall:** core_stall is combinational in the same cycle as the conflict. The core's held access executes the cycle after debug releases the port.
- **Reset:**
  - Registered state: state=S_CORE, wait_cnt=0, dbg_rvalid=0, rd_owner=core.
  - While rst=1, the arbiter forces dmem_en=0, dmem_we=0, dbg_gnt=0 and core_stall=0.
  - Reset during S_LOCK, or with an outstanding read, drops the lock and suppresses dbg_rvalid on the next cycle.
- **Simultaneous events:**
  - If core_en and dbg_req rise together with wait_cnt<MAX_WAIT, the core wins and wait_cnt becomes 1.
  - If dbg_lock is asserted without dbg_req, it is ignored in S_CORE.
- **wait_cnt at grant:** wait_cnt==MAX_WAIT with dbg_gnt clears the counter on the same edge; the next conflict restarts the count at 0.
- **No same-cycle deassert:** the requester holds dbg_req/dbg_we/dbg_addr/dbg_wdata stable until dbg_gnt. The arbiter does not latch them.

## Test plan
- **Core only:** core write addr 0x010 = 0xDEADBEEF with we=4'hF, then read 0x010 -> core_stall=0 throughout; core_rdata=0xDEADBEEF on the cycle after the read; dbg_rvalid=0.
- **Debug with core idle:** debug read 0x010 -> dbg_gnt in the same cycle; dbg_rvalid=1 with dbg_rdata=0xDEADBEEF on the next cycle, for exactly one cycle.
- **Starvation bound:** MAX_WAIT=4, core_en=1 every cycle, dbg_req held -> dbg_gnt on the 5th cycle of the request with core_stall=1 only in that cycle; the core's held access completes the next cycle with data intact.
- **Lock burst:** dbg_lock=1 and 8 debug writes to 0x100..0x107 with dbg_req gaps, core_en=1 throughout -> core_stall=1 for the whole burst including gaps. After dbg_lock drops, the core is granted within 1 cycle, and DMEM holds all 8 values.
- **Byte writes:** debug writes we=4'b0100 data 0x00AB0000 to 0x010 -> a subsequent read returns 0xDEABBEEF.
- **Reset mid-lock:** assert rst for 1 cycle while in S_LOCK with a debug read granted -> next cycle dbg_rvalid=0; after release, state is S_CORE, wait_cnt=0, and a core request is granted immediately.

Source files
------------

// File: rtl/ama_riscv_dmem_arbiter.sv
// ama_riscv_dmem_arbiter: shares the single-port DMEM between the core and a debug/loader port,
// core first, with bounded debug starvation and a lock mode for debug bursts.
module ama_riscv_dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_en,
    input  logic [3:0]  core_we,
    input  logic [13:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic [31:0] core_rdata,
    input  logic        dbg_req,
    input  logic        dbg_lock,
    input  logic [3:0]  dbg_we,
    input  logic [13:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dmem_en,
    output logic [3:0]  dmem_we,
    output logic [13:0] dmem_addr,
    output logic [31:0] dmem_din,
    input  logic [31:0] dmem_dout
);
    typedef enum logic {S_CORE, S_LOCK} state_t;
    localparam logic [CNT_W-1:0] WMAX = CNT_W'(MAX_WAIT);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             rd_vld_q, rd_owner_q;
    logic             dbg_own, core_gnt, rd_acc;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CORE;
            wait_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            rd_vld_q <= rd_acc;
            if (rd_acc) rd_owner_q <= dbg_gnt;
        end
    end
    // Reset gates every grant so nothing reaches the DMEM while rst is high.
    always_comb begin
        dbg_own    = (state_q == S_LOCK) || (dbg_req && (!core_en || wait_q == WMAX));
        dbg_gnt    = !rst && dbg_req && dbg_own;
        core_gnt   = !rst && core_en && !dbg_own;
        core_stall = !rst && core_en && dbg_own;
        dmem_en    = core_gnt || dbg_gnt;
        dmem_we    = dbg_gnt ? dbg_we : (core_gnt ? core_we : 4'h0);
        dmem_addr  = dbg_own ? dbg_addr : core_addr;
        dmem_din   = dbg_own ? dbg_wdata : core_wdata;
        rd_acc     = dmem_en && (dmem_we == 4'h0);
        wait_d     = (!dbg_req || dbg_gnt) ? '0 : ((wait_q == WMAX) ? wait_q : wait_q + CNT_W'(1));
        state_d    = (state_q == S_CORE) ? ((dbg_gnt && dbg_lock) ? S_LOCK : S_CORE)
                                         : (dbg_lock ? S_LOCK : S_CORE);
    end
    assign dbg_rvalid = rd_vld_q && rd_owner_q;
    assign dbg_rdata  = dmem_dout;
    assign core_rdata = dmem_dout;
endmodule

// File: tb/tb_ama_riscv_dmem_arbiter.sv
// tb_ama_riscv_dmem_arbiter: directed stimulus with queued read expectations drained by a monitor.
module tb_ama_riscv_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        core_en, core_stall, dbg_req, dbg_lock, dbg_gnt, dbg_rvalid, dmem_en;
    logic [3:0]  core_we, dbg_we, dmem_we;
    logic [13:0] core_addr, dbg_addr, dmem_addr;
    logic [31:0] core_wdata, core_rdata, dbg_wdata, dbg_rdata, dmem_din, dmem_dout;
    logic [31:0] mem [16384];
    logic [31:0] core_q[$];
    logic [31:0] dbg_q[$];
    int total = 0;
    int bad = 0;

    ama_riscv_dmem_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .core_en(core_en), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
        .dmem_dout(dmem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural DMEM: byte-enabled write, 1-cycle registered read.
    always @(posedge clk) begin
        if (dmem_en) begin
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) mem[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];
            if (dmem_we == 4'h0) dmem_dout <= mem[dmem_addr];
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic core(input logic en, input logic [3:0] we, input logic [13:0] a, input logic [31:0] d);
        core_en = en; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic dbg(input logic rq, input logic lk, input logic [3:0] we, input logic [13:0] a, input logic [31:0] d);
        dbg_req = rq; dbg_lock = lk; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    // Monitor: a core read completes after a non-stalled read cycle; debug reads on dbg_rvalid.
    initial begin
        logic cf;
        forever begin
            @(negedge clk);
            cf = !rst && core_en && !core_stall && (core_we == 4'h0);
            @(posedge clk);
            #1;
            if (cf) begin
                if (core_q.size() == 0) chk("core_unexpected_read", 32'd1, 32'd0);
                else chk("core_rdata", core_rdata, core_q.pop_front());
            end
            if (dbg_rvalid === 1'b1) begin
                if (dbg_q.size() == 0) chk("dbg_unexpected_rvalid", 32'd1, 32'd0);
                else chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        core(1, 4'hF, 14'h010, 32'h1);
        dbg(1, 1, 4'hF, 14'h010, 32'h2);
        step(); #1;
        chk("rst_dmem_en", 32'(dmem_en), 0);
        chk("rst_dmem_we", 32'(dmem_we), 0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 0);
        chk("rst_core_stall", 32'(core_stall), 0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
        step();
        rst = 1'b0;
        dbg(0, 0, 0, 0, 0);
        // core only: write then read
        core(1, 4'hF, 14'h010, 32'hDEADBEEF); #1;
        chk("c_wr_stall", 32'(core_stall), 0);
        chk("c_wr_we", 32'(dmem_we), 32'hF);
        step();
        core(1, 4'h0, 14'h010, 0); core_q.push_back(32'hDEADBEEF); #1;
        chk("c_rd_stall", 32'(core_stall), 0);
        step();
        core(0, 0, 0, 0); #1;
        chk("c_rd_no_dbg_rvalid", 32'(dbg_rvalid), 0);
        // debug read with core idle
        dbg(1, 0, 4'h0, 14'h010, 0); dbg_q.push_back(32'hDEADBEEF); #1;
        chk("d_rd_gnt", 32'(dbg_gnt), 1);
        chk("d_rd_addr", 32'(dmem_addr), 32'h010);
        step();
        dbg(0, 0, 0, 0, 0); #1;
        chk("d_rvalid_1", 32'(dbg_rvalid), 1);
        step(); #1;
        chk("d_rvalid_0", 32'(dbg_rvalid), 0);
        // starvation bound: grant in the 5th cycle
        dbg(1, 0, 4'h0, 14'h010, 0); dbg_q.push_back(32'hDEADBEEF);
        for (int k = 1; k <= 5; k++) begin
            core(1, 4'hF, 14'(32'h20 + k), 32'h1000_0000 + k); #1;
            chk($sformatf("starve_gnt_%0d", k), 32'(dbg_gnt), (k == 5) ? 1 : 0);
            chk($sformatf("starve_stall_%0d", k), 32'(core_stall), (k == 5) ? 1 : 0);
            step();
        end
        dbg(0, 0, 0, 0, 0); #1;
        chk("held_stall", 32'(core_stall), 0);
        chk("held_addr", 32'(dmem_addr), 32'h025);
        chk("held_we", 32'(dmem_we), 32'hF);
        step();
        core(1, 4'h0, 14'h025, 0); core_q.push_back(32'h1000_0005); step();
        core(1, 4'h0, 14'h021, 0); core_q.push_back(32'h1000_0001); step();
        // lock burst under continuous core writes
        core(1, 4'hF, 14'h300, 32'h3333_3333);
        for (int k = 1; k <= 5; k++) begin
            dbg(1, 1, 4'hF, 14'h100, 32'hA5A5_0000); #1;
            chk($sformatf("lock_acq_gnt_%0d", k), 32'(dbg_gnt), (k == 5) ? 1 : 0);
            step();
        end
        for (int i = 1; i < 8; i++) begin
            dbg(0, 1, 0, 0, 0); #1;
            chk("lock_gap_stall", 32'(core_stall), 1);
            chk("lock_gap_en", 32'(dmem_en), 0);
            step();
            dbg(1, 1, 4'hF, 14'(32'h100 + i), 32'hA5A5_0000 + i); #1;
            chk("lock_wr_gnt", 32'(dbg_gnt), 1);
            chk("lock_wr_stall", 32'(core_stall), 1);
            chk("lock_wr_addr", 32'(dmem_addr), 32'h100 + i);
            step();
        end
        dbg(0, 0, 0, 0, 0); #1;
        chk("unlock_edge_stall", 32'(core_stall), 1);
        step(); #1;
        chk("unlock_stall", 32'(core_stall), 0);
        chk("unlock_addr", 32'(dmem_addr), 32'h300);
        step();
        core(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            dbg(1, 0, 4'h0, 14'(32'h100 + i), 0); dbg_q.push_back(32'hA5A5_0000 + i); #1;
            chk("burst_rd_gnt", 32'(dbg_gnt), 1);
            step();
        end
        dbg(0, 0, 0, 0, 0);
        core(1, 4'h0, 14'h300, 0); core_q.push_back(32'h3333_3333); step();
        core(0, 0, 0, 0);
        // byte write
        dbg(1, 0, 4'b0100, 14'h010, 32'h00AB_0000); #1;
        chk("byte_gnt", 32'(dbg_gnt), 1);
        chk("byte_we", 32'(dmem_we), 32'h4);
        step();
        dbg(1, 0, 4'h0, 14'h010, 0); dbg_q.push_back(32'hDEAB_BEEF); step();
        dbg(0, 0, 0, 0, 0);
        core(1, 4'h0, 14'h010, 0); core_q.push_back(32'hDEAB_BEEF); step();
        core(0, 0, 0, 0);
        // reset mid-lock
        dbg(1, 1, 4'hF, 14'h050, 32'h5555_5555); #1;
        chk("rl_gnt", 32'(dbg_gnt), 1);
        step();
        rst = 1'b1;
        dbg(1, 1, 4'h0, 14'h010, 0); #1;
        chk("rl_rst_gnt", 32'(dbg_gnt), 0);
        chk("rl_rst_en", 32'(dmem_en), 0);
        step();
        rst = 1'b0;
        dbg(0, 1, 0, 0, 0);
        core(1, 4'h0, 14'h010, 0); core_q.push_back(32'hDEAB_BEEF); #1;
        chk("rl_rvalid", 32'(dbg_rvalid), 0);
        chk("rl_core_stall", 32'(core_stall), 0);
        chk("rl_core_en", 32'(dmem_en), 1);
        step();
        core(0, 0, 0, 0); dbg(0, 0, 0, 0, 0);
        step(); step(); #1;
        chk("core_q_empty", 32'(core_q.size()), 0);
        chk("dbg_q_empty", 32'(dbg_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
